// File: rtl/debit_pin_pkg.sv
// Shared state encoding and parameter defaults for the PIN lockout controller and its bench.
package debit_pin_pkg;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } pin_state_e;

  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 50000;

endpackage

// File: rtl/pin_lockout_ctrl_rise_detect.sv
// Registered 1-bit rising-edge detector: rise_o is high while d_i is high and was low last cycle.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;
  logic hist_d;

  assign hist_d = d_i;
  assign rise_o = d_i & ~hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/pin_lockout_ctrl.sv
// PIN result consumer: grant pulse, consecutive-failure counting and timed keypad lockout.
// Optional ALARM_EN build adds a sticky alarm after ALARM_LOCKS lockouts without a grant.
module pin_lockout_ctrl
  import debit_pin_pkg::*;
#(
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int TRY_W       = 2,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int LOCK_W      = 16
`ifdef ALARM_EN
  , parameter int ALARM_LOCKS = 2
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             correct,
  input  logic             incorrect,
  output logic             grant,
  output logic             locked,
  output logic             pin_clear,
  output logic [TRY_W-1:0] tries_left
`ifdef ALARM_EN
  , output logic           alarm
`endif
);

  localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);

  logic c_rise;
  logic i_rise;

  rise_detect u_rise_correct (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (correct),
    .rise_o (c_rise)
  );

  rise_detect u_rise_incorrect (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (incorrect),
    .rise_o (i_rise)
  );

  pin_state_e       state_q;
  logic [TRY_W-1:0] fail_cnt_q;
  logic [LOCK_W-1:0] timer_q;
  logic             grant_q;
  logic             locked_q;
  logic             pin_clear_q;
  logic [TRY_W-1:0] tries_left_q;

  logic [TRY_W:0]   fail_inc;
  logic             fail_last;

  // One bit wider so the compare cannot wrap when fail_cnt sits at its top value.
  assign fail_inc  = {1'b0, fail_cnt_q} + (TRY_W+1)'(1);
  assign fail_last = fail_inc >= (TRY_W+1)'(MAX_TRIES);

`ifdef ALARM_EN
  localparam int LC_W = $clog2(ALARM_LOCKS + 1);
  logic [LC_W-1:0] lock_cnt_q;
  logic            alarm_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= READY;
      fail_cnt_q   <= '0;
      timer_q      <= '0;
      grant_q      <= 1'b0;
      locked_q     <= 1'b0;
      pin_clear_q  <= 1'b0;
      tries_left_q <= MAX_T;
`ifdef ALARM_EN
      lock_cnt_q   <= '0;
      alarm_q      <= 1'b0;
`endif
    end else begin
      grant_q <= 1'b0;
      case (state_q)
        READY: begin
          // A simultaneous correct edge is deliberately dropped: fail-safe.
          if (i_rise) begin
            pin_clear_q <= 1'b1;
            if (!fail_last) begin
              fail_cnt_q   <= fail_inc[TRY_W-1:0];
              tries_left_q <= MAX_T - fail_inc[TRY_W-1:0];
            end else begin
              state_q      <= LOCKED;
              fail_cnt_q   <= MAX_T;
              timer_q      <= LOCK_W'(LOCK_CYCLES - 1);
              locked_q     <= 1'b1;
              tries_left_q <= '0;
`ifdef ALARM_EN
              if (int'(lock_cnt_q) < ALARM_LOCKS) lock_cnt_q <= lock_cnt_q + LC_W'(1);
              if (int'(lock_cnt_q) + 1 >= ALARM_LOCKS) alarm_q <= 1'b1;
`endif
            end
          end else if (c_rise) begin
            state_q      <= GRANT;
            fail_cnt_q   <= '0;
            grant_q      <= 1'b1;
            pin_clear_q  <= 1'b1;
            tries_left_q <= MAX_T;
`ifdef ALARM_EN
            lock_cnt_q   <= '0;
`endif
          end else begin
            pin_clear_q <= 1'b0;
          end
        end
        GRANT: begin
          state_q      <= READY;
          pin_clear_q  <= 1'b0;
          tries_left_q <= MAX_T;
        end
        LOCKED: begin
          // Entry cycle loads LOCK_CYCLES-1, so the exit on zero gives exactly LOCK_CYCLES.
          if (timer_q == '0) begin
            state_q      <= READY;
            locked_q     <= 1'b0;
            pin_clear_q  <= 1'b0;
            fail_cnt_q   <= '0;
            tries_left_q <= MAX_T;
          end else begin
            timer_q <= timer_q - LOCK_W'(1);
          end
        end
        default: begin
          state_q     <= READY;
          locked_q    <= 1'b0;
          pin_clear_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign locked     = locked_q;
  assign pin_clear  = pin_clear_q;
  assign tries_left = tries_left_q;
`ifdef ALARM_EN
  assign alarm      = alarm_q;
`endif

endmodule

// File: tb/tb_pin_lockout_ctrl.sv
// Scoreboard bench for pin_lockout_ctrl with LOCK_CYCLES=8; alarm checks only when ALARM_EN is defined.
module tb_pin_lockout_ctrl;
  import debit_pin_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       correct = 1'b0;
  logic       incorrect = 1'b0;
  logic       grant;
  logic       locked;
  logic       pin_clear;
  logic [1:0] tries_left;
`ifdef ALARM_EN
  logic       alarm;
`endif

  pin_lockout_ctrl #(
    .MAX_TRIES   (DEF_MAX_TRIES),
    .TRY_W       (2),
    .LOCK_CYCLES (8),
    .LOCK_W      (16)
`ifdef ALARM_EN
    , .ALARM_LOCKS (2)
`endif
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .correct    (correct),
    .incorrect  (incorrect),
    .grant      (grant),
    .locked     (locked),
    .pin_clear  (pin_clear),
    .tries_left (tries_left)
`ifdef ALARM_EN
    , .alarm    (alarm)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       g;
    logic       l;
    logic       p;
    logic [1:0] t;
    logic       a;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_tag  = "reset";
  logic  exp_alarm_g = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: compares outputs 1 time unit after every clock edge or reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, "_grant"},  {7'd0, grant},      {7'd0, e.g});
        chk({e.tag, "_locked"}, {7'd0, locked},     {7'd0, e.l});
        chk({e.tag, "_clear"},  {7'd0, pin_clear},  {7'd0, e.p});
        chk({e.tag, "_tries"},  {6'd0, tries_left}, {6'd0, e.t});
`ifdef ALARM_EN
        chk({e.tag, "_alarm"},  {7'd0, alarm},      {7'd0, e.a});
`endif
      end
    end
  end

  task automatic push(input logic g, input logic l, input logic p, input logic [1:0] t);
    exp_t e;
    e.tag = cur_tag; e.g = g; e.l = l; e.p = p; e.t = t; e.a = exp_alarm_g;
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs at the falling edge, expect outputs after the next rising edge.
  task automatic cyc(input logic c, input logic i,
                     input logic g, input logic l, input logic p, input logic [1:0] t);
    @(negedge clk);
    rst_n = 1'b1; correct = c; incorrect = i;
    push(g, l, p, t);
  endtask

  task automatic rcyc();
    @(negedge clk);
    rst_n = 1'b0; correct = 1'b0; incorrect = 1'b0;
    exp_alarm_g = 1'b0;
    push(1'b0, 1'b0, 1'b0, 2'd3);
  endtask

  // Assert reset between clock edges; the monitor checks outputs before any rising edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    exp_alarm_g = 1'b0;
    push(1'b0, 1'b0, 1'b0, 2'd3);
    rst_n = 1'b0; correct = 1'b0; incorrect = 1'b0;
  endtask

  task automatic lockout(input logic hold_inc, input logic poke, input logic set_alarm);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    if (set_alarm) exp_alarm_g = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
    for (int k = 1; k < 8; k++) begin
      logic [3:0] kv;
      kv = 4'(k);
      cyc(poke & kv[0], hold_inc, 1'b0, 1'b1, 1'b1, 2'd0);
    end
    cyc(1'b0, hold_inc, 1'b0, 1'b0, 1'b0, 2'd3);
    cyc(1'b0, hold_inc, 1'b0, 1'b0, 1'b0, 2'd3);
    cyc(1'b0, 1'b0,     1'b0, 1'b0, 1'b0, 2'd3);
    cyc(1'b0, 1'b0,     1'b0, 1'b0, 1'b0, 2'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    cur_tag = "reset";
    repeat (3) rcyc();

    cur_tag = "t1_grant";
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

    cur_tag = "t2_two_wrong";
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

    cur_tag = "t3_lockout";
    lockout(1'b0, 1'b1, 1'b0);

    cur_tag = "t4_both";
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

    cur_tag = "t5_held";
    lockout(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

    cur_tag = "t6_midlock";
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    async_reset();
    rcyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

`ifdef ALARM_EN
    cur_tag = "t7_alarm";
    lockout(1'b0, 1'b0, 1'b0);
    lockout(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
    async_reset();
    rcyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
`endif

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
